// File: rtl/instruction_fetch_controller_if.sv
// Handshake bundle shared by the fetch controller, the instruction memory and decode.
// The controller drives the master side; memory, decode and branch logic form the slave side.
interface instruction_fetch_controller_if;
    logic        start;
    logic        mem_load;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_data;
    logic [63:0] inst_pc;
    logic        busy;
    logic        halted;
    logic        timeout_err;

    modport master (
        input  start, mem_data, mem_ready, redirect_valid, redirect_pc, inst_ready,
        output mem_load, mem_req, mem_addr, inst_valid, inst_data, inst_pc,
               busy, halted, timeout_err
    );

    modport slave (
        output start, mem_data, mem_ready, redirect_valid, redirect_pc, inst_ready,
        input  mem_load, mem_req, mem_addr, inst_valid, inst_data, inst_pc,
               busy, halted, timeout_err
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Front-end fetch sequencer: triggers the image load, walks the PC one 8-byte word at a time,
// buffers returned words in a small FIFO for decode, and handles redirects, halt and timeouts.
module instruction_fetch_controller #(
    parameter int unsigned NUM_INSTRUCTIONS = 5,
    parameter logic [63:0] RESET_PC         = 64'd0,
    parameter int unsigned FIFO_DEPTH       = 2,
    parameter int unsigned MAX_WAIT         = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    instruction_fetch_controller_if.master bus
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [63:0]       PC_LIMIT  = 64'(NUM_INSTRUCTIONS) << 3;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_HALT  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t              state_r;
    logic [63:0]         pc_r;
    logic [63:0]         mem_addr_r;
    logic                mem_req_r;
    logic                mem_load_r;
    logic                busy_r;
    logic                halted_r;
    logic                timeout_err_r;
    logic [WAIT_W-1:0]   wait_r;

    logic [63:0]         fifo_pc_r   [FIFO_DEPTH];
    logic [63:0]         fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [CNT_W-1:0]    count_r;

    logic                in_fetch_s;
    logic                redir_s;
    logic [63:0]         redir_pc_s;
    logic                push_s;
    logic                pop_s;
    logic                nonempty_s;
    logic                inst_valid_s;
    logic                timeout_s;
    logic                flush_s;
    logic                issue_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A redirect outranks both the memory response and the decode pop in the same cycle.
    assign in_fetch_s   = (state_r == S_FETCH);
    assign redir_s      = bus.redirect_valid && (in_fetch_s || (state_r == S_HALT));
    assign redir_pc_s   = bus.redirect_pc & ~64'h7;
    assign push_s       = in_fetch_s && mem_req_r && bus.mem_ready && !redir_s;
    assign nonempty_s   = (count_r != CNT_W'(0));
    assign inst_valid_s = nonempty_s && !bus.redirect_valid;
    assign pop_s        = inst_valid_s && bus.inst_ready;
    assign timeout_s    = in_fetch_s && mem_req_r && !bus.mem_ready && !redir_s
                          && (wait_r == WAIT_LAST);
    assign flush_s      = redir_s || timeout_s;
    assign issue_ok_s   = !mem_req_r && (pc_r < PC_LIMIT) && (count_r < CNT_FULL);

    assign bus.mem_load    = mem_load_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.busy        = busy_r;
    assign bus.halted      = halted_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.inst_valid  = inst_valid_s;
    assign bus.inst_data   = nonempty_s ? fifo_data_r[rd_ptr_r] : 64'd0;
    assign bus.inst_pc     = nonempty_s ? fifo_pc_r[rd_ptr_r]   : 64'd0;

    // Instruction buffer: circular FIFO of {pc, word}, flushed on redirect or timeout
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]   <= pc_r;
                fifo_data_r[wr_ptr_r] <= bus.mem_data;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Control FSM: sequencing, PC walk, single-outstanding request and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            pc_r          <= RESET_PC;
            mem_addr_r    <= 64'd0;
            mem_req_r     <= 1'b0;
            mem_load_r    <= 1'b0;
            busy_r        <= 1'b0;
            halted_r      <= 1'b0;
            timeout_err_r <= 1'b0;
            wait_r        <= WAIT_W'(0);
        end else begin
            mem_load_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r    <= S_LOAD;
                        pc_r       <= RESET_PC;
                        mem_load_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // The first request is launched on the edge leaving LOAD.
                    state_r <= S_FETCH;
                    if (issue_ok_s) begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_r;
                    end
                end
                S_FETCH: begin
                    if (redir_s) begin
                        pc_r      <= redir_pc_s;
                        mem_req_r <= 1'b0;
                        wait_r    <= WAIT_W'(0);
                    end else if (mem_req_r) begin
                        if (bus.mem_ready) begin
                            pc_r      <= pc_r + 64'd8;
                            mem_req_r <= 1'b0;
                            wait_r    <= WAIT_W'(0);
                        end else if (timeout_s) begin
                            state_r       <= S_ERROR;
                            mem_req_r     <= 1'b0;
                            busy_r        <= 1'b0;
                            timeout_err_r <= 1'b1;
                            wait_r        <= WAIT_W'(0);
                        end else begin
                            wait_r <= wait_r + WAIT_W'(1);
                        end
                    end else if (issue_ok_s) begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_r;
                    end else if (count_r == CNT_W'(0)) begin
                        // Nothing in flight, buffer drained and PC past the image.
                        state_r  <= S_HALT;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (redir_s) begin
                        state_r   <= S_FETCH;
                        pc_r      <= redir_pc_s;
                        mem_req_r <= 1'b0;
                        wait_r    <= WAIT_W'(0);
                        busy_r    <= 1'b1;
                        halted_r  <= 1'b0;
                    end
                end
                S_ERROR: begin
                    state_r <= S_ERROR;
                end
                default: begin
                    state_r   <= S_IDLE;
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    halted_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Scoreboard bench: stimulus pushes the expected {pc, word} stream, a monitor pops on every
// decode handshake; a randomised memory/decode environment drives the controller.
module tb_instruction_fetch_controller;
    localparam int          NUM   = 5;
    localparam int          DEPTH = 2;
    localparam int          MAXW  = 15;
    localparam logic [63:0] LIMIT = 64'd40;

    localparam int M_MANUAL = 0, M_ALWAYS = 1, M_NEVER = 2, M_RANDOM = 3;
    localparam int I_ALWAYS = 0, I_NEVER = 1, I_RANDOM = 2;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] img [NUM];
    exp_t        exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          mem_mode;
    int          inst_mode;
    int          mem_acc;
    logic        mon_prev_wait;
    logic [63:0] mon_prev_addr;

    instruction_fetch_controller_if bus ();

    instruction_fetch_controller #(
        .NUM_INSTRUCTIONS(NUM),
        .RESET_PC(64'd0),
        .FIFO_DEPTH(DEPTH),
        .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a (re)start at target delivers every in-range word from the aligned target up.
    task automatic expect_from(input logic [63:0] target);
        logic [63:0] p;
        exp_t e;
        exp_q.delete();
        for (p = target & ~64'h7; p < LIMIT; p = p + 64'd8) begin
            e.pc   = p;
            e.data = img[int'(p >> 3)];
            exp_q.push_back(e);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_load"},    64'(bus.mem_load),    64'd0);
        chk({tag, "_mem_req"},     64'(bus.mem_req),     64'd0);
        chk({tag, "_mem_addr"},    bus.mem_addr,         64'd0);
        chk({tag, "_inst_valid"},  64'(bus.inst_valid),  64'd0);
        chk({tag, "_inst_data"},   bus.inst_data,        64'd0);
        chk({tag, "_inst_pc"},     bus.inst_pc,          64'd0);
        chk({tag, "_busy"},        64'(bus.busy),        64'd0);
        chk({tag, "_halted"},      64'(bus.halted),      64'd0);
        chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;
        mem_mode           = M_MANUAL;
        bus.mem_ready      = 1'b0;
        exp_q.delete();
        step(1);
        check_zero(tag);
        step(1);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input bit honoured);
        bus.start = 1'b1;
        if (honoured) expect_from(64'd0);
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n;
        n = 0;
        while (!bus.halted && n < budget) begin
            step(1);
            n++;
        end
        chk({name, "_halt_reached"}, 64'(bus.halted), 64'd1);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Instruction memory model: returns the image word for mem_addr, ready per mode
    initial begin : mem_driver
        int waited;
        waited = 0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_data = (bus.mem_addr < LIMIT) ? img[int'(bus.mem_addr >> 3)] : 64'hbad0_bad0_bad0_bad0;
            case (mem_mode)
                M_ALWAYS: bus.mem_ready = 1'b1;
                M_NEVER:  bus.mem_ready = 1'b0;
                M_RANDOM: begin
                    if (bus.mem_req && waited >= 6) bus.mem_ready = 1'b1;
                    else bus.mem_ready = ($urandom_range(0, 2) != 0);
                    if (bus.mem_req && !bus.mem_ready) waited++;
                    else waited = 0;
                end
                default: waited = 0;
            endcase
        end
    end

    // Decode-side acceptance per mode
    initial begin : inst_driver
        forever begin
            @(posedge clk);
            #2;
            case (inst_mode)
                I_ALWAYS: bus.inst_ready = 1'b1;
                I_NEVER:  bus.inst_ready = 1'b0;
                default:  bus.inst_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every decode handshake and watches the request port
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_wait = 1'b0;
            end else begin
                if (bus.inst_valid && bus.inst_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL inst_unexpected: got pc 0x%0h, expected no word", bus.inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", bus.inst_pc, e.pc);
                        chk("inst_data", bus.inst_data, e.data);
                    end
                end
                if (bus.mem_req) begin
                    chk("mem_addr_in_range", 64'(bus.mem_addr < LIMIT), 64'd1);
                    if (mon_prev_wait) chk("mem_addr_stable", bus.mem_addr, mon_prev_addr);
                    if (bus.mem_ready) mem_acc++;
                end
                mon_prev_wait = bus.mem_req && !bus.mem_ready && !bus.redirect_valid;
                mon_prev_addr = bus.mem_addr;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int redirs;
        logic [63:0] tgt;
        for (int i = 0; i < NUM; i++) img[i] = {$urandom, $urandom};
        reset = 1'b1;
        bus.start = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'd0;
        bus.mem_ready = 1'b0;
        bus.mem_data = 64'd0;
        bus.inst_ready = 1'b0;
        mem_mode = M_MANUAL;
        inst_mode = I_ALWAYS;
        mem_acc = 0;
        mon_prev_wait = 1'b0;
        mon_prev_addr = 64'd0;

        // Reset state and idle without start
        do_reset("rst");
        step(2);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_mem_req", 64'(bus.mem_req), 64'd0);

        // Straight line with latency checks
        mem_mode = M_ALWAYS;
        inst_mode = I_ALWAYS;
        pulse_start(1'b1);
        chk("lat_mem_load", 64'(bus.mem_load), 64'd1);
        chk("lat_busy", 64'(bus.busy), 64'd1);
        step(1);
        chk("lat_mem_req", 64'(bus.mem_req), 64'd1);
        chk("lat_mem_addr", bus.mem_addr, 64'd0);
        chk("lat_load_pulse", 64'(bus.mem_load), 64'd0);
        step(1);
        chk("lat_inst_valid", 64'(bus.inst_valid), 64'd1);
        chk("lat_inst_pc", bus.inst_pc, 64'd0);
        wait_halt(60, "straight");
        chk("straight_mem_req", 64'(bus.mem_req), 64'd0);
        chk("straight_busy", 64'(bus.busy), 64'd0);

        // Backpressure: decode stalls, the buffer fills to its depth and requests stop
        do_reset("bp_rst");
        mem_mode = M_ALWAYS;
        inst_mode = I_NEVER;
        pulse_start(1'b1);
        mem_acc = 0;
        step(11);
        chk("bp_words_buffered", 64'(mem_acc), 64'(DEPTH));
        chk("bp_mem_req_low", 64'(bus.mem_req), 64'd0);
        chk("bp_inst_valid", 64'(bus.inst_valid), 64'd1);
        inst_mode = I_ALWAYS;
        wait_halt(60, "bp");

        // Redirect to 0x13 while a request is pending and ready rises the same cycle
        do_reset("rd_rst");
        inst_mode = I_NEVER;
        pulse_start(1'b1);
        step(1);
        chk("rd_req0", 64'(bus.mem_req), 64'd1);
        bus.mem_ready = 1'b1;
        step(1);
        bus.mem_ready = 1'b0;
        chk("rd_word0_buffered", 64'(bus.inst_valid), 64'd1);
        step(1);
        chk("rd_req1_addr", bus.mem_addr, 64'd8);
        step(2);
        chk("rd_pending", 64'(bus.mem_req), 64'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h13;
        bus.mem_ready = 1'b1;
        expect_from(64'h13);
        @(negedge clk);
        chk("rd_inst_valid_masked", 64'(bus.inst_valid), 64'd0);
        step(1);
        bus.redirect_valid = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("rd_req_dropped", 64'(bus.mem_req), 64'd0);
        chk("rd_flushed", 64'(bus.inst_valid), 64'd0);
        step(1);
        chk("rd_new_req", 64'(bus.mem_req), 64'd1);
        chk("rd_new_addr", bus.mem_addr, 64'h10);
        mem_mode = M_RANDOM;
        inst_mode = I_RANDOM;
        wait_halt(200, "rd");

        // Memory never answers: timeout, sticky error, start ignored, reset clears
        do_reset("to_rst");
        mem_mode = M_NEVER;
        inst_mode = I_ALWAYS;
        pulse_start(1'b1);
        step(1);
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            step(1);
        end
        chk("to_req_cycles", 64'(n), 64'(MAXW));
        chk("to_err", 64'(bus.timeout_err), 64'd1);
        chk("to_busy", 64'(bus.busy), 64'd0);
        chk("to_halted", 64'(bus.halted), 64'd0);
        exp_q.delete();
        pulse_start(1'b0);
        chk("to_start_ignored", 64'(bus.mem_load), 64'd0);
        step(3);
        chk("to_err_sticky", 64'(bus.timeout_err), 64'd1);
        chk("to_no_req", 64'(bus.mem_req), 64'd0);
        do_reset("to_clr");

        // Redirect out of HALT, plus a start pulse mid-fetch that must not reload
        mem_mode = M_RANDOM;
        inst_mode = I_RANDOM;
        pulse_start(1'b1);
        wait_halt(200, "h1");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h8;
        expect_from(64'h8);
        step(1);
        bus.redirect_valid = 1'b0;
        chk("h_resume_busy", 64'(bus.busy), 64'd1);
        chk("h_resume_halted", 64'(bus.halted), 64'd0);
        step(2);
        pulse_start(1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("h_start_no_load", 64'(bus.mem_load), 64'd0);
            step(1);
        end
        wait_halt(200, "h2");

        // Randomised runs with random images and random (often misaligned) redirects
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NUM; i++) img[i] = {$urandom, $urandom};
            do_reset("rnd_rst");
            mem_mode = M_RANDOM;
            inst_mode = I_RANDOM;
            pulse_start(1'b1);
            redirs = 3;
            for (int c = 0; c < 400; c++) begin
                if (bus.halted && redirs == 0) break;
                if (redirs > 0 && ((bus.busy && !bus.mem_load) || bus.halted)
                    && $urandom_range(0, 9) == 0) begin
                    tgt = 64'($urandom_range(0, 60));
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc = tgt;
                    expect_from(tgt);
                    redirs--;
                end else begin
                    bus.redirect_valid = 1'b0;
                end
                step(1);
            end
            bus.redirect_valid = 1'b0;
            wait_halt(100, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
Sequences the instruction memory for the core front end. On `start` it triggers the program image load, then walks the PC in 8-byte steps and issues one read at a time over a req/ready handshake. Returned words are buffered in a small FIFO and handed to decode over a valid/ready interface. It also handles branch redirects, end-of-program halt and memory-timeout errors.

Parameters:
NUM_INSTRUCTIONS, 5, number of 64-bit words in the instruction memory; the fetch window is [0, NUM_INSTRUCTIONS*8).
RESET_PC, 64'd0, PC value after reset and after `start`.
FIFO_DEPTH, 2, instruction buffer entries (≥1).
MAX_WAIT, 15, cycles `mem_req` may stay high without `mem_ready` before the timeout error.

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins load and fetch; honoured only in IDLE
mem_load  out  1  one-cycle pulse to the memory image-load input (read_instruct)
mem_req  out  1  read request to the instruction memory
mem_addr  out  64  byte address of the request; the memory indexes by addr>>3
mem_data  in  64  returned instruction word
mem_ready  in  1  `mem_data` is valid for the current request
redirect_valid  in  1  branch redirect this cycle
redirect_pc  in  64  redirect target byte address
inst_valid  out  1  FIFO head is valid
inst_ready  in  1  decode accepts the head
inst_data  out  64  head instruction word
inst_pc  out  64  byte address of the head word
busy  out  1  high in LOAD or FETCH
halted  out  1  high in HALT
timeout_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (synchronous): state=IDLE, pc=RESET_PC, FIFO empty, wait counter=0. Every output is 0 from the edge at which `reset` is sampled high. Reset mid-transaction drops `mem_req` and discards any response.
- States: IDLE, LOAD, FETCH, HALT, ERROR.
  - IDLE: `start`=1 → LOAD; pc=RESET_PC.
  - LOAD: `mem_load`=1 for exactly this one cycle → FETCH.
  - FETCH: issue requests per the rules below.
  - HALT: idle until a redirect or reset.
  - ERROR: only reset exits.
  - `start` outside IDLE is ignored.
- Fetch issue rules:
  - At most one request outstanding.
  - Issue when pc < NUM_INSTRUCTIONS*8 and (FIFO count + outstanding) < FIFO_DEPTH.
  - `mem_req`/`mem_addr` are registered. `mem_addr`=pc and stays stable while `mem_req` is high.
  - A response is taken in the cycle `mem_req` && `mem_ready`. In that cycle: push {pc, mem_data}, pc += 8, drop `mem_req` next cycle.
  - The next request may issue the cycle after a response (at most one word per 2 cycles).
- Wait counter:
  - Increments each cycle `mem_req`=1 and `mem_ready`=0; resets on acceptance.
  - When the counter reaches MAX_WAIT: → ERROR, `timeout_err`=1, `mem_req`=0, FIFO flushed.
- End of program: in FETCH, when pc ≥ NUM_INSTRUCTIONS*8 with nothing outstanding and the FIFO empty → HALT.
- Output side:
  - `inst_valid` = FIFO non-empty && !`redirect_valid`.
  - Pop on `inst_valid` && `inst_ready`.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - FIFO order is preserved.
- Redirect (`redirect_valid`=1 in FETCH or HALT):
  - FIFO flushed; no pop that cycle.
  - Outstanding request abandoned. A `mem_ready` in the same cycle is discarded; `mem_req` drops next cycle.
  - pc = redirect_pc & ~64'h7 (misaligned targets are aligned down).
  - Wait counter cleared; state → FETCH.
  - The first new request issues 1 cycle later.
  - An out-of-range target reaches HALT via the end-of-program rule.
  - Redirect is ignored in IDLE, LOAD and ERROR.
  - Redirect takes priority over push and pop in the same cycle.
- Width rule: pc arithmetic is 64-bit unsigned; wrap at 2^64 is not special-cased.
- Latency, with `mem_ready` tied high and `start` at cycle 0: `mem_load` at cycle 1, first `mem_req` at cycle 2, `inst_valid` at cycle 3.

Test Plan:
- Straight line, NUM_INSTRUCTIONS=5, `mem_ready` always high, `inst_ready` always high → `inst_pc` 0, 8, 16, 24, 32 in order with the matching words, then `halted`=1, `mem_req`=0, `busy`=0.
- Backpressure, `inst_ready`=0 for 10 cycles → exactly FIFO_DEPTH=2 words buffered and `mem_req` stays low. Release `inst_ready` → remaining words delivered in order, with no loss or duplication.
- Redirect to 0x13 while a request is pending and `mem_ready` rises the same cycle → that response is discarded, FIFO emptied, `inst_valid`=0 that cycle, next `mem_addr`=0x10.
- `mem_ready` held low with MAX_WAIT=15 → ERROR after 15 cycles of `mem_req`, `timeout_err`=1 sticky, `start` ignored. Reset → all outputs 0, state IDLE.
- Redirect to 0x8 while `halted` → FETCH resumes at 0x8 and delivers words 1..4, then HALT again. A second `start` pulse mid-FETCH has no effect on `mem_load`.
